powlib_busrsp: RTL and testbench

POWLIB_BUSRSP -- requirements
Module: powlib_busrsp

---
 rtl/powlib_busrsp_pkg.sv | 11 +
 rtl/powlib_busfifo.sv | 47 ++++
 rtl/powlib_busrsp_mem.sv | 23 ++
 rtl/powlib_flipflop.sv | 26 ++
 rtl/powlib_busrsp.sv | 79 +++++++
 tb/tb_powlib_busrsp.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/powlib_busrsp_pkg.sv
// Shared constants and helpers for the bus responder slice.
package powlib_busrsp_pkg;
  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  // Unsigned window test, widened to 32 bits so base+size never wraps.
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction
endpackage

// File: rtl/powlib_busfifo.sv
// Valid/ready FIFO; wrnf rises once NFS or fewer free slots remain.
module powlib_busfifo #(
  parameter int W   = 8,
  parameter int D   = 8,
  parameter int NFS = 0,
  parameter bit EAR = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wrdata,
  input  logic         wrvld,
  output logic         wrrdy,
  output logic         wrnf,
  output logic [W-1:0] rddata,
  output logic         rdvld,
  input  logic         rdrdy
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  ram [D];
  logic [PW-1:0] wp, rp, wp_nx, rp_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          push, pop;

  assign push   = wrvld && wrrdy;
  assign pop    = rdvld && rdrdy;
  assign wrrdy  = !rst && (cnt != CW'(D));
  assign wrnf   = !rst && (cnt >= CW'(D - NFS));
  assign rdvld  = !rst && (cnt != '0);
  assign rddata = ram[rp];

  always_comb begin
    wp_nx  = wp;
    rp_nx  = rp;
    if (push) wp_nx = (wp == PW'(D - 1)) ? '0 : wp + PW'(1);
    if (pop)  rp_nx = (rp == PW'(D - 1)) ? '0 : rp + PW'(1);
    cnt_nx = cnt + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk)
    if (push) ram[wp] <= wrdata;

  powlib_flipflop #(.W(PW), .EAR(EAR)) u_wp  (.clk, .rst, .d(wp_nx),  .q(wp));
  powlib_flipflop #(.W(PW), .EAR(EAR)) u_rp  (.clk, .rst, .d(rp_nx),  .q(rp));
  powlib_flipflop #(.W(CW), .EAR(EAR)) u_cnt (.clk, .rst, .d(cnt_nx), .q(cnt));
endmodule

// File: rtl/powlib_busrsp_mem.sv
// Single-port synchronous RAM, write-first, registered read, never cleared.
module powlib_busrsp_mem #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      ram[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= ram[addr];
    end
  end
endmodule

// File: rtl/powlib_flipflop.sv
// Generic register; RSTEN=0 gives a plain data flop, EAR selects async reset.
module powlib_flipflop #(
  parameter int         W     = 1,
  parameter logic [W-1:0] INIT = '0,
  parameter bit         RSTEN = 1'b1,
  parameter bit         EAR   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (!RSTEN) begin : g_nrst
    logic unused_rst;
    assign unused_rst = rst;
    always_ff @(posedge clk) q <= d;
  end else if (EAR) begin : g_arst
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= INIT;
      else     q <= d;
  end else begin : g_srst
    always_ff @(posedge clk)
      if (rst) q <= INIT;
      else     q <= d;
  end
endmodule

// File: rtl/powlib_busrsp.sv
// Memory-mapped bus responder: input FIFO -> s0 pop -> s1 RAM read -> s2 -> output FIFO.
module powlib_busrsp
  import powlib_busrsp_pkg::*;
#(
  parameter int B_AW   = 2,
  parameter int B_DW   = 4,
  parameter int B_BASE = 0,
  parameter int B_SIZE = 3,
  parameter int D      = 8,
  parameter bit EAR    = 1'b0,
  parameter     ID     = "BUSRSP",
  parameter bit EDBG   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_DW-1:0] wrdata,
  input  logic [B_AW-1:0] wraddr,
  input  logic            wrop,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic            wrnf,
  output logic [B_DW-1:0] rddata,
  output logic [B_AW-1:0] rdaddr,
  output logic            rdvld,
  input  logic            rdrdy
);
  localparam int IW = B_DW + B_AW + 1;
  localparam int OW = B_DW + B_AW;
  localparam int MW = (B_SIZE > 0) ? $clog2(B_SIZE + 1) : 1;

  logic [IW-1:0]   s0_word;
  logic            s0_vld, s0_op, s0_hit, pop, mem_we;
  logic [B_AW-1:0] s0_addr;
  logic [B_DW-1:0] s0_data;
  logic [MW-1:0]   mem_addr;
  logic [B_DW-1:0] mem_q, s2_d, s2_data;
  logic            s1_vld, s1_oor, s2_vld, out_nf, out_rdy;
  logic [B_AW-1:0] s1_addr, s2_addr;
  logic [OW-1:0]   rd_word;

  powlib_busfifo #(.W(IW), .D(D), .NFS(1), .EAR(EAR)) u_in (
    .clk, .rst, .wrdata({wrop, wraddr, wrdata}), .wrvld, .wrrdy, .wrnf,
    .rddata(s0_word), .rdvld(s0_vld), .rdrdy(pop));

  assign {s0_op, s0_addr, s0_data} = s0_word;
  // Output FIFO reserves two slots for reads already in s1/s2, so s1/s2 never stall.
  assign pop      = s0_vld && !out_nf;
  assign s0_hit   = in_window(32'(s0_addr), 32'(B_BASE), 32'(B_BASE + B_SIZE));
  assign mem_we   = pop && (s0_op == OP_WR) && s0_hit;
  assign mem_addr = s0_hit ? MW'(s0_addr - B_AW'(B_BASE)) : '0;

  powlib_busrsp_mem #(.DW(B_DW), .DEPTH(B_SIZE + 1), .AW(MW)) u_mem (
    .clk, .we(mem_we), .addr(mem_addr), .wdata(s0_data), .rdata(mem_q));

  powlib_flipflop #(.W(1), .EAR(EAR)) u_s1_vld (
    .clk, .rst, .d(pop && (s0_op == OP_RD)), .q(s1_vld));
  powlib_flipflop #(.W(B_AW), .RSTEN(1'b0)) u_s1_addr (
    .clk, .rst, .d(s0_data[B_AW-1:0]), .q(s1_addr));
  powlib_flipflop #(.W(1), .RSTEN(1'b0)) u_s1_oor (
    .clk, .rst, .d(!s0_hit), .q(s1_oor));

  assign s2_d = s1_oor ? '1 : mem_q;

  powlib_flipflop #(.W(1), .EAR(EAR)) u_s2_vld (
    .clk, .rst, .d(s1_vld), .q(s2_vld));
  powlib_flipflop #(.W(B_AW), .RSTEN(1'b0)) u_s2_addr (
    .clk, .rst, .d(s1_addr), .q(s2_addr));
  powlib_flipflop #(.W(B_DW), .RSTEN(1'b0)) u_s2_data (
    .clk, .rst, .d(s2_d), .q(s2_data));

  powlib_busfifo #(.W(OW), .D(8), .NFS(2), .EAR(EAR)) u_out (
    .clk, .rst, .wrdata({s2_data, s2_addr}), .wrvld(s2_vld), .wrrdy(out_rdy), .wrnf(out_nf),
    .rddata(rd_word), .rdvld, .rdrdy);

  assign {rddata, rdaddr} = rd_word;

  logic unused_cfg;
  assign unused_cfg = ^{out_rdy, EDBG, ID};
endmodule

// File: tb/tb_powlib_busrsp.sv
// Bench for powlib_busrsp: vector table, corner sequences, random scoreboard run.
module tb_powlib_busrsp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] wrdata, rddata;
  logic [1:0] wraddr, rdaddr;
  logic       wrop, wrvld, wrrdy, wrnf, rdvld, rdrdy;
  logic [3:0] b_wrdata, b_rddata;
  logic [1:0] b_wraddr, b_rdaddr;
  logic       b_wrop, b_wrvld, b_wrrdy, b_wrnf, b_rdvld, b_rdrdy;

  typedef struct packed {
    logic       op;
    logic [1:0] addr;
    logic [3:0] data;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl [10];
  int         n_cmp = 0, n_bad = 0;
  logic [3:0] mdl [4];
  logic [5:0] expq [$];
  bit         acc, rnd_rdy, auto_rel, saw_nf;
  int         stall_cnt, n_rsp;

  always #5 clk = ~clk;

  powlib_busrsp u_a (
    .clk(clk), .rst(rst), .wrdata(wrdata), .wraddr(wraddr), .wrop(wrop), .wrvld(wrvld),
    .wrrdy(wrrdy), .wrnf(wrnf), .rddata(rddata), .rdaddr(rdaddr), .rdvld(rdvld), .rdrdy(rdrdy));

  powlib_busrsp #(.B_BASE(1), .B_SIZE(1)) u_b (
    .clk(clk), .rst(rst), .wrdata(b_wrdata), .wraddr(b_wraddr), .wrop(b_wrop), .wrvld(b_wrvld),
    .wrrdy(b_wrrdy), .wrnf(b_wrnf), .rddata(b_rddata), .rdaddr(b_rdaddr), .rdvld(b_rdvld),
    .rdrdy(b_rdrdy));

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic bad(input string nm, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", nm, what);
  endtask

  // One clock: observe handshakes at negedge, then step past the posedge.
  task automatic cyc();
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      acc = wrvld && wrrdy;
      if (wrvld && !wrrdy) stall_cnt++;
      if (wrnf) saw_nf = 1'b1;
      if (rdvld && rdrdy) begin
        n_rsp++;
        if (expq.size() == 0)
          bad("extra_rsp", $sformatf("got data %0h addr %0h, expected no response", rddata, rdaddr));
        else
          cmp("rsp", {rddata, rdaddr}, expq.pop_front());
      end
    end
    @(posedge clk); #1;
    if (rnd_rdy) rdrdy = 1'($urandom_range(0, 1));
    if (auto_rel && stall_cnt >= 5) rdrdy = 1'b1;
  endtask

  // Offer one request until accepted; model applies it in acceptance order.
  task automatic send(input logic op, input logic [1:0] a, input logic [3:0] d,
                      input bit use_tbl, input logic [3:0] texp);
    int n = 0;
    wrvld = 1'b1; wrop = op; wraddr = a; wrdata = d;
    do begin cyc(); n++; end while (!acc && n < 300);
    wrvld = 1'b0;
    if (!acc) bad("send_timeout", "request never accepted");
    else if (op == 1'b0) mdl[a] = d;
    else expq.push_back({use_tbl ? texp : mdl[a], d[1:0]});
  endtask

  task automatic drain();
    int n = 0;
    wrvld = 1'b0; rnd_rdy = 1'b0; rdrdy = 1'b1;
    while (expq.size() != 0 && n < 400) begin cyc(); n++; end
    if (expq.size() != 0) bad("drain_timeout", $sformatf("%0d responses missing", expq.size()));
    repeat (4) cyc();
  endtask

  task automatic b_req(input logic op, input logic [1:0] a, input logic [3:0] d);
    int n = 0;
    bit got = 1'b0;
    b_wrvld = 1'b1; b_wrop = op; b_wraddr = a; b_wrdata = d;
    while (!got && n < 50) begin
      @(negedge clk); got = b_wrrdy;
      @(posedge clk); #1; n++;
    end
    b_wrvld = 1'b0;
    if (!got) bad("b_req_timeout", "request never accepted");
  endtask

  task automatic b_rsp(input string nm, input logic [3:0] ed, input logic [1:0] ea);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (b_rdvld) begin got = 1'b1; cmp(nm, {b_rddata, b_rdaddr}, {ed, ea}); end
      @(posedge clk); #1; n++;
    end
    if (!got) bad(nm, "no response within 50 cycles");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wrvld = 0; wrop = 0; wraddr = 0; wrdata = 0; rdrdy = 1;
    b_wrvld = 0; b_wrop = 0; b_wraddr = 0; b_wrdata = 0; b_rdrdy = 1;
    rnd_rdy = 0; auto_rel = 0; saw_nf = 0; stall_cnt = 0; n_rsp = 0;

    tbl[0] = '{1'b0, 2'd1, 4'hA, 4'h0};
    tbl[1] = '{1'b1, 2'd1, 4'h3, 4'hA};
    tbl[2] = '{1'b0, 2'd2, 4'h5, 4'h0};
    tbl[3] = '{1'b1, 2'd2, 4'h1, 4'h5};
    tbl[4] = '{1'b0, 2'd0, 4'h3, 4'h0};
    tbl[5] = '{1'b0, 2'd3, 4'hC, 4'h0};
    tbl[6] = '{1'b1, 2'd0, 4'h2, 4'h3};
    tbl[7] = '{1'b1, 2'd3, 4'h0, 4'hC};
    tbl[8] = '{1'b0, 2'd1, 4'h6, 4'h0};
    tbl[9] = '{1'b1, 2'd1, 4'h1, 4'h6};

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    cmp("rst_rdvld", rdvld, 0); cmp("rst_wrrdy", wrrdy, 0); cmp("rst_wrnf", wrnf, 0);
    cmp("rst_b_rdvld", b_rdvld, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    cmp("idle_wrrdy", wrrdy, 1); cmp("idle_rdvld", rdvld, 0); cmp("idle_wrnf", wrnf, 0);
    @(posedge clk); #1;

    // Vector table, issued back to back
    n_rsp = 0;
    for (int i = 0; i < 10; i++) send(tbl[i].op, tbl[i].addr, tbl[i].data, 1'b1, tbl[i].exp);
    drain();
    cmp("tbl_rsp_cnt", n_rsp, 5);

    // Window B_BASE=1, B_SIZE=1
    b_req(1'b0, 2'd1, 4'h2);
    b_req(1'b0, 2'd2, 4'h9);
    b_req(1'b1, 2'd0, 4'h2);  b_rsp("b_oor_rd0", 4'hF, 2'd2);
    b_req(1'b0, 2'd3, 4'h7);
    b_req(1'b1, 2'd3, 4'h1);  b_rsp("b_oor_rd3", 4'hF, 2'd1);
    b_req(1'b1, 2'd1, 4'h0);  b_rsp("b_in_rd1", 4'h2, 2'd0);
    b_req(1'b1, 2'd2, 4'h3);  b_rsp("b_in_rd2", 4'h9, 2'd3);

    // Backpressure: 20 reads with rdrdy low until the input side stalls
    rdrdy = 0; auto_rel = 1; stall_cnt = 0; saw_nf = 0; n_rsp = 0;
    for (int i = 0; i < 20; i++) send(1'b1, 2'(i), 4'(i), 1'b0, 4'h0);
    auto_rel = 0;
    drain();
    cmp("stall_seen", stall_cnt > 0, 1);
    cmp("nf_seen", saw_nf, 1);
    cmp("stall_rsp_cnt", n_rsp, 20);

    // Random mix against the model
    rnd_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) cyc();
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom), 1'b0, 4'h0);
    end
    drain();

    // Reset with reads in flight
    rdrdy = 0;
    for (int i = 0; i < 3; i++) send(1'b1, 2'(i), 4'(i), 1'b0, 4'h0);
    cyc();
    rst = 1; expq.delete();
    @(negedge clk);
    cmp("mid_rst_rdvld", rdvld, 0); cmp("mid_rst_wrrdy", wrrdy, 0); cmp("mid_rst_wrnf", wrnf, 0);
    @(posedge clk); #1; rst = 0; rdrdy = 1;
    @(negedge clk);
    cmp("post_rst_rdvld", rdvld, 0);
    @(posedge clk); #1;
    repeat (6) cyc();
    n_rsp = 0;
    for (int i = 0; i < 4; i++) send(1'b1, 2'(i), 4'(3 - i), 1'b0, 4'h0);
    drain();
    cmp("post_rst_rsp_cnt", n_rsp, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
